// File: rtl/prefix_add_pkg.sv
// Shared constants, FSM state type and the generate/propagate dot operator.
// Purely declarative: no latency or backpressure of its own.
package prefix_add_pkg;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_CHUNK = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Prefix dot cell: {g, p} = (g_hi, p_hi) o (g_lo, p_lo)
    function automatic logic [1:0] pg_dot(input logic g_hi, input logic p_hi,
                                          input logic g_lo, input logic p_lo);
        return {g_hi | (p_hi & g_lo), p_hi & p_lo};
    endfunction

endpackage

// File: rtl/prefix_add_seq_if.sv
// Operand/result handshake bundle for prefix_add_seq; the sub signal exists only with SUB_EN.
// Both sides use valid/ready; slave is the adder side, master the producer/consumer side.
interface prefix_add_seq_if
    import prefix_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport slave (
        input  in_valid, a, b,
`ifdef SUB_EN
        input  sub,
`endif
        input  out_ready,
        output in_ready, out_valid, sum, cout
    );

    modport master (
        output in_valid, a, b,
`ifdef SUB_EN
        output sub,
`endif
        output out_ready,
        input  in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/prefix_add16.sv
// 16-bit combinational Kogge-Stone adder with carry in/out, built from pg_dot cells.
// Zero latency, no handshake.
module prefix_add16
    import prefix_add_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout
);
    wire [15:0] g_l [0:4];
    wire [15:0] p_l [0:4];
    wire [16:0] c;

    assign g_l[0] = a & b;
    assign p_l[0] = a ^ b;

    for (genvar l = 1; l <= 4; l++) begin : g_lvl
        localparam int D = 1 << (l - 1);
        for (genvar i = 0; i < 16; i++) begin : g_bit
            if (i >= D) begin : g_dot
                assign {g_l[l][i], p_l[l][i]} =
                    pg_dot(g_l[l-1][i], p_l[l-1][i], g_l[l-1][i-D], p_l[l-1][i-D]);
            end else begin : g_pass
                assign g_l[l][i] = g_l[l-1][i];
                assign p_l[l][i] = p_l[l-1][i];
            end
        end
    end

    // Final group terms span bit 0..i, so cin folds in with one extra AND-OR per bit.
    assign c    = {g_l[4] | (p_l[4] & {16{cin}}), cin};
    assign s    = p_l[0] ^ c[15:0];
    assign cout = c[16];

endmodule

// File: rtl/prefix_add_seq.sv
// Sequential WIDTH-bit add (sub with SUB_EN) through one CHUNK-bit prefix adder, one slice per cycle.
// Result valid WIDTH/CHUNK cycles after accept; held in DONE until out_ready, in_ready only in IDLE.
module prefix_add_seq
    import prefix_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
)(
    input  logic            clk,
    input  logic            rst_n,
    prefix_add_seq_if.slave bus
);
    localparam int NS = WIDTH / CHUNK;
    localparam int KW = (NS > 1) ? $clog2(NS) : 1;

    if (((WIDTH % CHUNK) != 0) || (CHUNK != 16)) begin : g_bad_cfg
        $error("prefix_add_seq: WIDTH must be a multiple of CHUNK and CHUNK must be 16");
    end

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             sub_q, sub_d;

    logic [CHUNK-1:0] a_sl, b_sl, s_sl;
    logic             co_sl;

    assign a_sl = a_q[k_q*CHUNK +: CHUNK];
    assign b_sl = b_q[k_q*CHUNK +: CHUNK] ^ {CHUNK{sub_q}};

    prefix_add16 u_add (
        .a    (a_sl),
        .b    (b_sl),
        .cin  (carry_q),
        .s    (s_sl),
        .cout (co_sl)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
`ifdef SUB_EN
                    sub_d   = bus.sub;
                    carry_d = bus.sub;
`else
                    sub_d   = 1'b0;
                    carry_d = 1'b0;
`endif
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[k_q*CHUNK +: CHUNK] = s_sl;
                carry_d = co_sl;
                k_d     = k_q + KW'(1);
                if (k_q == KW'(NS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = carry_q;

endmodule

// File: tb/tb_prefix_add_seq.sv
// Directed self-checking bench for prefix_add_seq; SUB_EN cases compile only with that macro.
module tb_prefix_add_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    prefix_add_seq_if #(.WIDTH(64)) bus ();

    prefix_add_seq #(.WIDTH(64), .CHUNK(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Drive one operation from IDLE; returns at accept edge + 1.
    task automatic issue(input logic [63:0] av, input logic [63:0] bv);
        bus.a        = av;
        bus.b        = bv;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!bus.out_valid && cyc < 20);
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #3;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.sum !== 64'd0) begin bad++; $display("FAIL rst_sum got=%h exp=0", bus.sum); end
        total++; if (bus.cout !== 1'b0) begin bad++; $display("FAIL rst_cout got=%b exp=0", bus.cout); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_wrap();
        int cyc;
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        wait_done(cyc);
        total++; if (cyc !== 4) begin bad++; $display("FAIL wrap_latency got=%0d exp=4", cyc); end
        total++; if (bus.sum !== 64'd0) begin bad++; $display("FAIL wrap_sum got=%h exp=0", bus.sum); end
        total++; if (bus.cout !== 1'b1) begin bad++; $display("FAIL wrap_cout got=%b exp=1", bus.cout); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL wrap_in_ready_done got=%b exp=0", bus.in_ready); end
        release_result();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL wrap_drop got=%b exp=0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL wrap_idle got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_carry_cross();
        int cyc;
        issue(64'h0000_0000_0000_FFFF, 64'd1);
        wait_done(cyc);
        total++; if (bus.sum !== 64'h0000_0000_0001_0000) begin bad++; $display("FAIL cross_sum got=%h exp=0000000000010000", bus.sum); end
        total++; if (bus.cout !== 1'b0) begin bad++; $display("FAIL cross_cout got=%b exp=0", bus.cout); end
        release_result();
    endtask

    task automatic test_hold();
        int cyc;
        issue(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111);
        wait_done(cyc);
        for (int i = 0; i < 3; i++) begin
            bus.a        = 64'hDEAD_BEEF_0000_0000 + 64'(i);
            bus.b        = 64'h0BAD_F00D_0000_0000;
            bus.in_valid = ~bus.in_valid;
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL hold_valid[%0d] got=%b exp=1", i, bus.out_valid); end
            total++; if (bus.sum !== 64'h2345_6789_ABCD_F001) begin bad++; $display("FAIL hold_sum[%0d] got=%h exp=23456789abcdf001", i, bus.sum); end
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL hold_in_ready[%0d] got=%b exp=0", i, bus.in_ready); end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        release_result();
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL hold_exit got=v%b/r%b exp=v0/r1", bus.out_valid, bus.in_ready); end
        total++; if (bus.sum !== 64'h2345_6789_ABCD_F001 || bus.cout !== 1'b0) begin bad++; $display("FAIL hold_after got=%h/%b exp=23456789abcdf001/0", bus.sum, bus.cout); end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        issue(64'h0001_0001_0001_0001, 64'h0001_0001_0001_0001);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.sum !== 64'd0) begin bad++; $display("FAIL midrst_sum got=%h exp=0", bus.sum); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%b exp=1", bus.in_ready); end
        issue(64'd3, 64'd4);
        wait_done(cyc);
        total++; if (cyc !== 4) begin bad++; $display("FAIL midrst_latency got=%0d exp=4", cyc); end
        total++; if (bus.sum !== 64'd7 || bus.cout !== 1'b0) begin bad++; $display("FAIL midrst_sum7 got=%h/%b exp=7/0", bus.sum, bus.cout); end
        release_result();
    endtask

`ifdef SUB_EN
    task automatic test_sub();
        int cyc;
        bus.sub = 1'b1;
        issue(64'd5, 64'd7);
        wait_done(cyc);
        total++; if (bus.sum !== 64'hFFFF_FFFF_FFFF_FFFE || bus.cout !== 1'b0) begin bad++; $display("FAIL sub_5m7 got=%h/%b exp=fffffffffffffffe/0", bus.sum, bus.cout); end
        release_result();
        issue(64'd7, 64'd5);
        wait_done(cyc);
        total++; if (bus.sum !== 64'd2 || bus.cout !== 1'b1) begin bad++; $display("FAIL sub_7m5 got=%h/%b exp=2/1", bus.sum, bus.cout); end
        release_result();
        bus.sub = 1'b0;
    endtask
`endif

    task automatic test_back_to_back();
        logic [63:0] op_a [3];
        logic [63:0] op_b [3];
        logic [63:0] exp_s [3];
        logic        exp_c [3];
        int idx_in;
        int idx_out;
        logic acc;
        op_a[0] = 64'd1;                   op_b[0] = 64'd2;
        exp_s[0] = 64'd3;                  exp_c[0] = 1'b0;
        op_a[1] = 64'h8000_0000_0000_0000; op_b[1] = 64'h8000_0000_0000_0000;
        exp_s[1] = 64'd0;                  exp_c[1] = 1'b1;
        op_a[2] = 64'h0123_4567_89AB_CDEF; op_b[2] = 64'h1111_1111_1111_1111;
        exp_s[2] = 64'h1234_5678_9ABC_DF00; exp_c[2] = 1'b0;
        idx_in  = 0;
        idx_out = 0;
        bus.a = op_a[0];
        bus.b = op_b[0];
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            acc = bus.in_ready & bus.in_valid;
            if (bus.out_valid) begin
                if (idx_out < 3) begin
                    total++; if (bus.sum !== exp_s[idx_out] || bus.cout !== exp_c[idx_out]) begin
                        bad++; $display("FAIL b2b_result[%0d] got=%h/%b exp=%h/%b", idx_out, bus.sum, bus.cout, exp_s[idx_out], exp_c[idx_out]);
                    end
                end
                idx_out++;
            end
            @(posedge clk); #1;
            if (acc) begin
                idx_in++;
                if (idx_in < 3) begin
                    bus.a = op_a[idx_in];
                    bus.b = op_b[idx_in];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        total++; if (idx_out !== 3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", idx_out); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
`ifdef SUB_EN
        bus.sub       = 1'b0;
`endif
        test_reset();
        test_wrap();
        test_carry_cross();
        test_hold();
        test_reset_mid_run();
`ifdef SUB_EN
        test_sub();
`endif
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prefix_add_seq.md
PREFIX_ADD_SEQ -- requirements
Module: prefix_add_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 64, total operand width in bits.
REQ-002 SHALL have parameter CHUNK, default 16, prefix-adder slice width processed per cycle.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  operands and op valid.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port sub  input  1  1 = A-B, 0 = A+B (present only with SUB_EN).
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port sum  output  WIDTH  result.
REQ-013 SHALL have port cout  output  1  carry out of MSB.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; in_ready = 1 only in IDLE.
REQ-015 SHALL capture a, b (and sub) on in_valid & in_ready and go IDLE->RUN; chunk index k = 0; carry register = sub (else 0).
REQ-016 SHALL in RUN, each cycle, add slice k of A and slice k of B (B inverted when sub=1) with the carry register through one CHUNK-bit prefix adder, write the result into sum slice k, and update the carry register with the slice carry out.
REQ-017 SHALL go RUN->DONE after slice WIDTH/CHUNK-1; out_valid asserts exactly WIDTH/CHUNK cycles after the accept edge (4 at defaults).
REQ-018 SHALL in DONE hold out_valid=1, sum and cout stable until out_ready=1; then go DONE->IDLE on that edge, out_valid drops next cycle.
REQ-019 SHALL ignore in_valid in RUN and DONE; operands are not re-sampled.
REQ-020 SHALL drive cout = final carry register; with sub=1, cout=1 means no borrow.
REQ-021 SHALL treat sum slices not yet computed in RUN as don't-care; only DONE values are architecturally defined.
REQ-022 SHALL produce results modulo 2^WIDTH; no saturation.

Reset
REQ-023 SHALL on rst_n=0, at any time including mid-RUN, enter IDLE immediately: out_valid=0, in_ready=1 after release, sum=0, cout=0, carry=0, k=0; the in-flight operation is discarded.
REQ-024 SHALL release reset synchronously to clk externally; no internal synchroniser.

Configuration
REQ-025 SHALL with SUB_EN defined provide port sub and subtraction per REQ-015/016.
REQ-026 SHALL without SUB_EN omit port sub, carry-in = 0, B never inverted; add behaviour identical otherwise.

Structure
REQ-027 SHALL place the state enum (IDLE, RUN, DONE) and default WIDTH/CHUNK constants in shared package prefix_add_pkg.
REQ-028 SHALL instantiate one sub-module prefix_add16: CHUNK-bit combinational Kogge-Stone adder built from the existing generate/propagate dot cells, inputs a, b, cin, outputs s, cout.
REQ-029 SHALL error at elaboration if WIDTH mod CHUNK != 0 or CHUNK != 16 for prefix_add16.

Verification
REQ-030 SHALL cover: a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> sum=0, cout=1, out_valid 4 cycles after accept.
REQ-031 SHALL cover: a=0x0000_0000_0000_FFFF, b=1 -> sum=0x0000_0000_0001_0000, cout=0 (carry crosses slice 0->1).
REQ-032 SHALL cover: out_ready held 0 for 3 cycles in DONE -> sum/cout stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-033 SHALL cover: rst_n pulsed low at RUN slice k=2 -> out_valid=0, sum=0, in_ready=1 after release; new op 3+4 -> sum=7.
REQ-034 SHALL cover (SUB_EN): a=5, b=7, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0; a=7, b=5 -> sum=2, cout=1.
REQ-035 SHALL cover: back-to-back ops with in_valid held 1 -> each accepted only in IDLE, one result per op, no loss or duplication.
